// File: rtl/pos_read_controller.sv
// rtl/pos_read_controller.sv - home/neighbour cell read address sequencer for the position preprocessor
module pos_read_controller #(
  parameter int PARTICLE_ID_WIDTH  = 7,
  parameter int NUM_NEIGHBOR_CELLS = 13
) (
  input  logic                                                clk,
  input  logic                                                rst,
  input  logic                                                start,
  input  logic [(NUM_NEIGHBOR_CELLS+1)*PARTICLE_ID_WIDTH-1:0] cell_particle_num,
  input  logic                                                back_pressure,
  output logic [PARTICLE_ID_WIDTH-1:0]                        ref_id,
  output logic [PARTICLE_ID_WIDTH-1:0]                        particle_id,
  output logic                                                phase,
  output logic                                                reading_particle_num,
  output logic                                                pause_reading,
  output logic [NUM_NEIGHBOR_CELLS:0]                         broadcast_done,
  output logic                                                busy,
  output logic                                                done
);

  localparam int W = PARTICLE_ID_WIDTH;
  localparam int N = NUM_NEIGHBOR_CELLS;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    READ_NUM,
    SWEEP,
    PHASE_END,
    DONE
  } state_t;

  state_t         state, state_d;
  logic [W-1:0]   cnt [0:N];
  logic [W-1:0]   max_nb, max_nb_d;
  logic [W-1:0]   home_cnt, home_cnt_d;
  logic [W-1:0]   nb_max;
  logic [W-1:0]   ref_d, pid_d;
  logic           phase_d, rpn_d, pause_d, busy_d, done_d;
  logic [N:0]     bd_d;
  logic           new_pair;

  // Largest neighbour count; only consumed while in LOAD.
  always_comb begin
    nb_max = '0;
    for (int c = 1; c <= N; c++) begin
      if (cnt[c] > nb_max) nb_max = cnt[c];
    end
  end

  // Next-state and next-output decode; every output is registered from these values.
  always_comb begin
    state_d    = state;
    ref_d      = ref_id;
    pid_d      = particle_id;
    phase_d    = phase;
    rpn_d      = 1'b0;
    pause_d    = 1'b0;
    bd_d       = '1;
    busy_d     = busy;
    done_d     = 1'b0;
    max_nb_d   = max_nb;
    home_cnt_d = home_cnt;
    new_pair   = 1'b0;

    case (state)
      IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          state_d = LOAD;
          busy_d  = 1'b1;
          ref_d   = '0;
          pid_d   = '0;
        end
      end
      LOAD: begin
        // An empty neighbourhood still sweeps one slot per reference particle.
        max_nb_d   = (nb_max == '0) ? W'(1) : nb_max;
        home_cnt_d = cnt[0];
        state_d    = READ_NUM;
        rpn_d      = 1'b1;
        bd_d       = '0;
        ref_d      = '0;
        pid_d      = '0;
      end
      READ_NUM: begin
        if (home_cnt == '0) begin
          state_d = PHASE_END;
          ref_d   = '0;
          pid_d   = '0;
        end else begin
          state_d  = SWEEP;
          ref_d    = W'(1);
          pid_d    = W'(1);
          new_pair = 1'b1;
        end
      end
      SWEEP: begin
        if (back_pressure) begin
          // Repeat the current pair; downstream discards it via pause_reading.
          pause_d = 1'b1;
          bd_d    = broadcast_done;
        end else if (particle_id < max_nb) begin
          pid_d    = particle_id + W'(1);
          new_pair = 1'b1;
        end else if (ref_id < home_cnt) begin
          ref_d    = ref_id + W'(1);
          pid_d    = W'(1);
          new_pair = 1'b1;
        end else begin
          state_d = PHASE_END;
          ref_d   = '0;
          pid_d   = '0;
        end
      end
      PHASE_END: begin
        ref_d = '0;
        pid_d = '0;
        if (!phase) begin
          phase_d = 1'b1;
          state_d = READ_NUM;
          rpn_d   = 1'b1;
          bd_d    = '0;
        end else begin
          phase_d = 1'b0;
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase

    // A cell is exhausted once the broadcast address passes its count.
    if (new_pair) begin
      for (int c = 0; c <= N; c++) begin
        bd_d[c] = (pid_d > cnt[c]);
      end
    end
  end

  // State, output and count registers; counts are captured only on an accepted start.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state                <= IDLE;
      ref_id               <= '0;
      particle_id          <= '0;
      phase                <= 1'b0;
      reading_particle_num <= 1'b0;
      pause_reading        <= 1'b0;
      broadcast_done       <= '1;
      busy                 <= 1'b0;
      done                 <= 1'b0;
      max_nb               <= '0;
      home_cnt             <= '0;
      for (int c = 0; c <= N; c++) cnt[c] <= '0;
    end else begin
      state                <= state_d;
      ref_id               <= ref_d;
      particle_id          <= pid_d;
      phase                <= phase_d;
      reading_particle_num <= rpn_d;
      pause_reading        <= pause_d;
      broadcast_done       <= bd_d;
      busy                 <= busy_d;
      done                 <= done_d;
      max_nb               <= max_nb_d;
      home_cnt             <= home_cnt_d;
      if (state == IDLE && start) begin
        for (int c = 0; c <= N; c++) cnt[c] <= cell_particle_num[c*W +: W];
      end
    end
  end

endmodule

// File: doc/pos_read_controller.md
# pos_read_controller

Address/sequence generator that sits directly upstream of the position data preprocessor. It walks the home cell and its neighbour cells each force-evaluation pass and drives the signals the preprocessor consumes: `ref_id`, `particle_id`, `phase`, `reading_particle_num`, `pause_reading` and `broadcast_done`. It runs two passes (phase 0, then phase 1) per `start`. It honours filter back-pressure and signals completion to the top-level scheduler.

## Interface

- PARTICLE_ID_WIDTH, 7: width of particle/reference indices and counts; address 0 of every cell holds its count.
- NUM_NEIGHBOR_CELLS, 13: neighbour cells; cell index 0 is home, 1..NUM_NEIGHBOR_CELLS are neighbours.

- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; starts a two-phase run; ignored unless in IDLE.
- cell_particle_num  in  (NUM_NEIGHBOR_CELLS+1)*PARTICLE_ID_WIDTH  per-cell counts, cell c at bits [c*W+:W]; sampled only on accepted `start`.
- back_pressure  in  1  filter buffers almost full; stalls the sweep.
- ref_id  out  PARTICLE_ID_WIDTH  home-cell reference particle address.
- particle_id  out  PARTICLE_ID_WIDTH  neighbour-particle address broadcast to all cells.
- phase  out  1  current pass, 0 then 1.
- reading_particle_num  out  1  high while address 0 (count word) is being read.
- pause_reading  out  1  current read cycle is a stall repeat; downstream ignores it.
- broadcast_done  out  NUM_NEIGHBOR_CELLS+1  bit c high when cell c has no valid particle at `particle_id`.
- busy  out  1  high from the cycle after `start` until `done`.
- done  out  1  one-cycle pulse at the end of phase 1.

## Operation

- All outputs are registered. Reset values:
  - `ref_id`, `particle_id`, `phase`, `reading_particle_num`, `pause_reading`, `busy`, `done` = 0.
  - `broadcast_done` = all ones.
- States: IDLE, LOAD, READ_NUM, SWEEP, PHASE_END, DONE.
- IDLE, on `start`:
  - Latch the per-cell counts `cnt[c]`.
  - Go to LOAD.
- LOAD (1 cycle):
  - Register `max_nb` = max of `cnt[1..N]`; a zero result is treated as 1 for the sweep length.
  - Register `home_cnt` = `cnt[0]`.
- READ_NUM (1 cycle):
  - Outputs `ref_id`=0, `particle_id`=0, `reading_particle_num`=1, `broadcast_done`=0.
  - Then:
    - if `home_cnt`=0, go to PHASE_END;
    - else go to SWEEP with `ref_id`=1, `particle_id`=1.
- SWEEP, each unstalled cycle:
  - `broadcast_done[c]` = (`particle_id` > `cnt[c]`) for c≥1.
  - `broadcast_done[0]` = (`particle_id` > `cnt[0]`).
  - Advance:
    - if `particle_id` < `max_nb`, increment `particle_id`;
    - else if `ref_id` < `home_cnt`, increment `ref_id` and set `particle_id`=1;
    - else go to PHASE_END.
- Stall: if `back_pressure` is sampled high in SWEEP:
  - Next cycle repeats the same `ref_id`/`particle_id`/`broadcast_done` with `pause_reading`=1.
  - Stall cycles repeat while `back_pressure` stays high.
  - The first cycle after `back_pressure` falls advances normally with `pause_reading`=0.
- PHASE_END (1 cycle):
  - Outputs idle, `broadcast_done` all ones.
  - If `phase`=0: set `phase`=1 and go to READ_NUM.
  - Else go to DONE.
- DONE (1 cycle):
  - `done`=1, `busy`=0, `phase` returns to 0.
  - Go to IDLE.
- Counters never wrap. `particle_id` ≤ `max_nb` ≤ 2^W−1, and comparisons are unsigned at W bits.
- `back_pressure` is ignored outside SWEEP. `start` is ignored while `busy`.
- Reset asserted mid-run returns immediately to IDLE with reset output values. No `done` is emitted.

## Timing

- `start` at cycle T:
  - `busy`=1 at T+1 (LOAD).
  - READ_NUM at T+2.
  - First SWEEP cycle at T+3.
- Unstalled cycle count per phase = 1 (READ_NUM) + `home_cnt`×`max_nb` (SWEEP) + 1 (PHASE_END).
- Total from `start` to `done`: 2 + 2×(2 + `home_cnt`×`max_nb`) cycles, plus stall cycles.
- The preprocessor adds its own one-cycle register delay. This block must not add combinational paths from `back_pressure` to outputs.

## Test plan

- Counts home=3, all neighbours=2, no back-pressure:
  - READ_NUM at T+2.
  - SWEEP pairs (1,1)(1,2)(2,1)(2,2)(3,1)(3,2), `broadcast_done`=0.
  - Phase 1 repeats the sequence.
  - `done` at T+18.
- Uneven counts home=2, cell1=4, cell5=1, others=0:
  - `max_nb`=4.
  - At `particle_id`=2, `broadcast_done[5]`=1 and `broadcast_done[1]`=0.
  - `broadcast_done[0]` rises at `particle_id`=3.
- Home count 0: each phase is READ_NUM→PHASE_END only, and `done` at T+6.
- `back_pressure` high for 3 cycles at pair (2,1):
  - Pair (2,1) is repeated 3 times with `pause_reading`=1.
  - Then (2,2) follows with `pause_reading`=0.
  - `done` is delayed exactly 3 cycles.
- `start` pulsed while busy: ignored, sequence unchanged. Reset mid-SWEEP: all outputs return to reset values asynchronously, and a new `start` runs cleanly.
- Counts all 127 (W=7): `particle_id` reaches 127 without wrap. Run completes with the correct cycle count.
